// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
// Holds the controller state encoding, default sizes and the per-lane skew rule.
package systolic_pkg;

    localparam int N_DEF     = 4;
    localparam int K_MAX_DEF = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_READOUT,
        S_DONE
    } ctrl_state_t;

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
    } lane_sel_t;

    // Lane `lane` reads operand t-lane while 0 <= t-lane < k_len, giving the diagonal skew.
    function automatic lane_sel_t lane_calc(input logic [31:0] t,
                                            input logic [31:0] lane,
                                            input logic [31:0] k_len);
        lane_sel_t s;
        s.en   = (t >= lane) && ((t - lane) < k_len);
        s.addr = s.en ? (t - lane) : 32'd0;
        return s;
    endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed read lane; row i of A and column i of B share identical timing.
module systolic_skew_lane
    import systolic_pkg::*;
#(
    parameter int LANE   = 0,
    parameter int T_W    = 9,
    parameter int ADDR_W = 8
) (
    input  logic [T_W-1:0]    t,
    input  logic [ADDR_W:0]   k_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr
);

    lane_sel_t sel;

    // An offset that cannot be represented in the buffer address never enables the read.
    always_comb begin
        sel     = lane_calc(32'(t), LANE, 32'(k_len));
        rd_en   = sel.en && (sel.addr[31:ADDR_W] == '0);
        rd_addr = sel.addr[ADDR_W-1:0];
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: clear, skewed feed, drain, row readout.
// Optional SYSTOLIC_CTRL_PERF_EN adds a saturating busy-cycle counter on port perf_cycles.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int  N      = N_DEF,
    parameter int  K_MAX  = K_MAX_DEF,
    localparam int ADDR_W = $clog2(K_MAX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W:0]       k_len,
    output logic                  busy,
    output logic                  pe_clr,
    output logic [N-1:0]          a_rd_en,
    output logic [N*ADDR_W-1:0]   a_rd_addr,
    output logic [N-1:0]          b_rd_en,
    output logic [N*ADDR_W-1:0]   b_rd_addr,
    output logic                  res_valid,
    output logic [$clog2(N)-1:0]  res_row,
    input  logic                  res_ready,
    output logic                  done
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    localparam int              T_W     = $clog2(K_MAX + N);
    localparam int              R_W     = $clog2(N);
    localparam int              KL_W    = ADDR_W + 1;
    localparam logic [KL_W-1:0] K_MAX_L = KL_W'(K_MAX);
    localparam logic [31:0]     N_U     = N;

    ctrl_state_t         state, state_n;
    logic [T_W-1:0]      t_cnt, t_n;
    logic [R_W-1:0]      r_cnt, r_n;
    logic [KL_W-1:0]     k_reg, k_n;
    logic [N-1:0]        lane_en;
    logic [N*ADDR_W-1:0] lane_addr;
    logic                cmd_ok;

    assign cmd_ok = start && (k_len != '0) && (k_len <= K_MAX_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            t_cnt <= '0;
            r_cnt <= '0;
            k_reg <= '0;
        end else begin
            state <= state_n;
            t_cnt <= t_n;
            r_cnt <= r_n;
            k_reg <= k_n;
        end
    end

    // t counts feed steps in FEED and is reused as the drain timer in DRAIN.
    always_comb begin
        state_n = state;
        t_n     = t_cnt;
        r_n     = r_cnt;
        k_n     = k_reg;
        case (state)
            S_IDLE: begin
                if (cmd_ok) begin
                    k_n     = k_len;
                    state_n = S_CLEAR;
                end
            end
            S_CLEAR: begin
                t_n     = '0;
                state_n = S_FEED;
            end
            S_FEED: begin
                if (32'(t_cnt) == 32'(k_reg) + N_U - 32'd2) begin
                    t_n     = '0;
                    state_n = S_DRAIN;
                end else begin
                    t_n = t_cnt + T_W'(1);
                end
            end
            S_DRAIN: begin
                if (32'(t_cnt) == N_U - 32'd1) begin
                    t_n     = '0;
                    r_n     = '0;
                    state_n = S_READOUT;
                end else begin
                    t_n = t_cnt + T_W'(1);
                end
            end
            S_READOUT: begin
                if (res_ready) begin
                    if (r_cnt == R_W'(N - 1)) begin
                        r_n     = '0;
                        state_n = S_DONE;
                    end else begin
                        r_n = r_cnt + R_W'(1);
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        systolic_skew_lane #(
            .LANE   (i),
            .T_W    (T_W),
            .ADDR_W (ADDR_W)
        ) u_lane (
            .t       (t_cnt),
            .k_len   (k_reg),
            .rd_en   (lane_en[i]),
            .rd_addr (lane_addr[i*ADDR_W +: ADDR_W])
        );
    end

    always_comb begin
        busy      = (state != S_IDLE);
        pe_clr    = (state == S_CLEAR);
        a_rd_en   = (state == S_FEED) ? lane_en   : '0;
        a_rd_addr = (state == S_FEED) ? lane_addr : '0;
        b_rd_en   = (state == S_FEED) ? lane_en   : '0;
        b_rd_addr = (state == S_FEED) ? lane_addr : '0;
        res_valid = (state == S_READOUT);
        res_row   = r_cnt;
        done      = (state == S_DONE);
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    // Restarts on an accepted command, then counts every busy cycle up to saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (state == S_IDLE) begin
            if (cmd_ok) begin
                perf_cycles <= '0;
            end
        end else if (perf_cycles != 32'hFFFF_FFFF) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl (N=4, K_MAX=256) using a cycle-phase reference model.
// Checks perf_cycles too when SYSTOLIC_CTRL_PERF_EN is defined.
module tb_systolic_ctrl;

    localparam int N     = 4;
    localparam int K_MAX = 256;
    localparam int AW    = 8;
    localparam int RW    = 2;
    localparam int VW    = 4 + 2*N + 2*N*AW + RW;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_FEED  = 2;
    localparam int P_DRAIN = 3;
    localparam int P_READ  = 4;
    localparam int P_DONE  = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic [AW:0]       k_len;
    logic              busy;
    logic              pe_clr;
    logic [N-1:0]      a_rd_en;
    logic [N*AW-1:0]   a_rd_addr;
    logic [N-1:0]      b_rd_en;
    logic [N*AW-1:0]   b_rd_addr;
    logic              res_valid;
    logic [RW-1:0]     res_row;
    logic              res_ready;
    logic              done;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    int nChecks;
    int nPass;

    systolic_ctrl #(
        .N     (N),
        .K_MAX (K_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .pe_clr    (pe_clr),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .b_rd_en   (b_rd_en),
        .b_rd_addr (b_rd_addr),
        .res_valid (res_valid),
        .res_row   (res_row),
        .res_ready (res_ready),
        .done      (done)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] observe();
        return {busy, pe_clr, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, res_valid, res_row, done};
    endfunction

    // Reference output for one cycle, derived from the phase and the skew rule directly.
    function automatic logic [VW-1:0] expected(input int phase, input int t, input int k, input int row);
        logic [N-1:0]    en;
        logic [N*AW-1:0] ad;
        logic [RW-1:0]   rr;
        en = '0;
        ad = '0;
        if (phase == P_FEED) begin
            for (int i = 0; i < N; i++) begin
                if (t >= i && t < i + k) begin
                    en[i]          = 1'b1;
                    ad[i*AW +: AW] = AW'(t - i);
                end
            end
        end
        rr = (phase == P_READ) ? RW'(row) : '0;
        return {phase != P_IDLE, phase == P_CLEAR, en, ad, en, ad, phase == P_READ, rr, phase == P_DONE};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issues one command and checks every cycle until the model's DONE cycle, then one idle cycle.
    task automatic applyStimulus(input int k, input int stall_row, input int stall_len,
                                 input int glitch, input bit rand_ready, output int done_cyc);
        int c, rows, stalled, drain_start, ro_start, phase, t;
        bit fin;
        drain_start = 2 + k + N - 1;
        ro_start    = drain_start + N;
        @(negedge clk);
        start     = 1'b1;
        k_len     = (AW+1)'(k);
        res_ready = 1'b1;
        c = 1; rows = 0; stalled = 0; fin = 1'b0; done_cyc = -1;
        while (!fin && c < 4000) begin
            @(negedge clk);
            start = 1'b0;
            t = 0;
            if (c == 1) phase = P_CLEAR;
            else if (c < drain_start) begin phase = P_FEED; t = c - 2; end
            else if (c < ro_start) phase = P_DRAIN;
            else if (rows < N) phase = P_READ;
            else phase = P_DONE;
            checkOutput($sformatf("k%0d_cyc%0d", k, c), 128'(observe()), 128'(expected(phase, t, k, rows)));
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
`ifdef SYSTOLIC_CTRL_PERF_EN
            if (phase == P_DONE) checkOutput($sformatf("perf_k%0d", k), 128'(perf_cycles), 128'(c - 1));
`endif
            res_ready = 1'b1;
            if (phase == P_READ) begin
                if (rand_ready) res_ready = 1'($urandom_range(0, 1));
                else if (rows == stall_row && stalled < stall_len) begin
                    res_ready = 1'b0;
                    stalled++;
                end
                if (res_ready) rows++;
            end
            if (c == glitch) begin
                start = 1'b1;
                k_len = (AW+1)'(7);
            end
            if (phase == P_DONE) fin = 1'b1;
            c++;
        end
        if (!fin) begin
            nChecks++;
            $display("[TB] FAIL timeout_k%0d: got no completion expected DONE within 4000 cycles", k);
        end
        @(negedge clk);
        checkOutput($sformatf("idle_after_k%0d", k), 128'(observe()), '0);
    endtask

    typedef struct {
        int k;
        int stall_row;
        int stall_len;
        int glitch;
        int exp_done;
    } vec_t;

    vec_t vecs[5];
    int   illegal[3];

    initial begin
        int dc;
        nChecks   = 0;
        nPass     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        res_ready = 1'b1;

        vecs[0] = '{k: 3,   stall_row: -1, stall_len: 0, glitch: 0, exp_done: 16};
        vecs[1] = '{k: 3,   stall_row: 1,  stall_len: 3, glitch: 0, exp_done: 19};
        vecs[2] = '{k: 3,   stall_row: -1, stall_len: 0, glitch: 4, exp_done: 16};
        vecs[3] = '{k: 1,   stall_row: -1, stall_len: 0, glitch: 0, exp_done: 14};
        vecs[4] = '{k: 256, stall_row: -1, stall_len: 0, glitch: 0, exp_done: 269};
        illegal = '{0, 257, 511};

        @(negedge clk);
        checkOutput("reset_during", 128'(observe()), '0);
        @(negedge clk);
        checkOutput("reset_hold", 128'(observe()), '0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset", 128'(observe()), '0);

        foreach (illegal[i]) begin
            @(negedge clk);
            start = 1'b1;
            k_len = (AW+1)'(illegal[i]);
            @(negedge clk);
            start = 1'b0;
            checkOutput($sformatf("illegal_k%0d", illegal[i]), 128'(observe()), '0);
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].k, vecs[i].stall_row, vecs[i].stall_len, vecs[i].glitch, 1'b0, dc);
            checkOutput($sformatf("done_cycle_v%0d", i), 128'(dc), 128'(vecs[i].exp_done));
        end

        // Abort a command mid-FEED with an asynchronous reset, then run a fresh one.
        @(negedge clk);
        start = 1'b1;
        k_len = (AW+1)'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset", 128'(observe()), '0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2, -1, 0, 0, 1'b0, dc);
        checkOutput("done_cycle_k2", 128'(dc), 128'(15));

        repeat (8) begin
            applyStimulus(int'($urandom_range(1, 12)), -1, 0, 0, 1'b1, dc);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
